// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: sequences core load/store requests onto a single-ported
// synchronous data memory. Word stores write directly. Loads read, wait one
// cycle for the memory and return the word or an extended byte lane. Byte
// stores perform a read-modify-write of the containing word.
// Optional build macro: MEM_ACCESS_ALIGN_CHECK_EN rejects misaligned word
// accesses with rsp_err instead of touching memory.
module mem_access_ctrl #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic              req_byte,
    input  logic              req_sext,
    input  logic [ADDR_W+1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_data,
    output logic              rsp_err,
    output logic              MEM_WrEn,
    output logic [ADDR_W-1:0] ALU_MEM_Addr,
    output logic [31:0]       MEM_DataIn,
    input  logic [31:0]       MEM_DataOut
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        WAIT  = 3'd2,
        WRITE = 3'd3,
        RESP  = 3'd4
    } state_t;

    state_t            state;
    state_t            state_next;

    logic              accept;
    logic              misaligned;
    logic              err_now;

    logic              we_q;
    logic              byte_q;
    logic              sext_q;
    logic [ADDR_W+1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rdata_q;

    logic [7:0]        lane_byte;
    logic [31:0]       load_result;
    logic [31:0]       merged_word;

    assign accept = req_valid && req_ready;

`ifdef MEM_ACCESS_ALIGN_CHECK_EN
    logic err_q;

    assign misaligned = !req_byte && (req_addr[1:0] != 2'b00);

    // Remember whether the accepted request was a rejected misaligned word access
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (accept) begin
            err_q <= misaligned;
        end
    end

    assign err_now = err_q;
`else
    assign misaligned = 1'b0;
    assign err_now    = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state selection: word stores skip the read, byte stores read first
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (misaligned) begin
                        state_next = RESP;
                    end else if (req_we && !req_byte) begin
                        state_next = WRITE;
                    end else begin
                        state_next = READ;
                    end
                end
            end
            READ:    state_next = WAIT;
            WAIT:    state_next = (we_q && byte_q) ? WRITE : RESP;
            WRITE:   state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Capture all request fields at acceptance so later input changes are ignored
    always_ff @(posedge clk) begin
        if (rst) begin
            we_q    <= 1'b0;
            byte_q  <= 1'b0;
            sext_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (accept) begin
            we_q    <= req_we;
            byte_q  <= req_byte;
            sext_q  <= req_sext;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
        end
    end

    // Memory read data is valid in WAIT, one cycle after the address in READ
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (state == WAIT) begin
            rdata_q <= MEM_DataOut;
        end
    end

    // Pick the addressed little-endian byte lane out of the captured word
    always_comb begin
        lane_byte = 8'h00;
        case (addr_q[1:0])
            2'd0:    lane_byte = rdata_q[7:0];
            2'd1:    lane_byte = rdata_q[15:8];
            2'd2:    lane_byte = rdata_q[23:16];
            2'd3:    lane_byte = rdata_q[31:24];
            default: lane_byte = 8'h00;
        endcase
    end

    // Load result: full word, or the lane sign/zero-extended
    always_comb begin
        load_result = rdata_q;
        if (byte_q) begin
            if (sext_q && lane_byte[7]) begin
                load_result = {24'hFF_FFFF, lane_byte};
            end else begin
                load_result = {24'h00_0000, lane_byte};
            end
        end
    end

    // Byte store merge: replace only the addressed lane of the captured word
    always_comb begin
        merged_word = rdata_q;
        case (addr_q[1:0])
            2'd0:    merged_word[7:0]   = wdata_q[7:0];
            2'd1:    merged_word[15:8]  = wdata_q[7:0];
            2'd2:    merged_word[23:16] = wdata_q[7:0];
            2'd3:    merged_word[31:24] = wdata_q[7:0];
            default: merged_word        = rdata_q;
        endcase
    end

    // Memory-side outputs are driven only in the states that use them
    always_comb begin
        MEM_WrEn     = 1'b0;
        ALU_MEM_Addr = '0;
        MEM_DataIn   = '0;
        case (state)
            READ, WAIT: begin
                ALU_MEM_Addr = addr_q[ADDR_W+1:2];
            end
            WRITE: begin
                MEM_WrEn     = 1'b1;
                ALU_MEM_Addr = addr_q[ADDR_W+1:2];
                MEM_DataIn   = byte_q ? merged_word : wdata_q;
            end
            default: begin
                MEM_WrEn     = 1'b0;
                ALU_MEM_Addr = '0;
                MEM_DataIn   = '0;
            end
        endcase
    end

    // Core-side handshake and response; data is zero for stores and rejected accesses
    always_comb begin
        req_ready = (state == IDLE);
        rsp_valid = (state == RESP);
        rsp_err   = 1'b0;
        rsp_data  = '0;
        if (state == RESP) begin
            rsp_err = err_now;
            if (!we_q && !err_now) begin
                rsp_data = load_result;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: drives mem_access_ctrl against a simple synchronous
// memory and compares responses and memory writes with a word-array model.
module tb_mem_access_ctrl;

    localparam int ADDR_W = 10;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic              req_byte;
    logic              req_sext;
    logic [ADDR_W+1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic [31:0]       rsp_data;
    logic              rsp_err;
    logic              MEM_WrEn;
    logic [ADDR_W-1:0] ALU_MEM_Addr;
    logic [31:0]       MEM_DataIn;
    logic [31:0]       MEM_DataOut;

    logic [31:0] mem     [0:1023];
    logic [31:0] ref_mem [0:1023];
    logic        mem_clear;

    int checks = 0;
    int errors = 0;

    logic        obs_ready;
    int          obs_lat;
    int          obs_wr_cnt;
    int          obs_wr_cyc;
    logic [31:0] obs_data;
    logic        obs_err;
    logic [9:0]  obs_wr_addr;
    logic [31:0] obs_wr_data;

    mem_access_ctrl #(.ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_byte     (req_byte),
        .req_sext     (req_sext),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_data     (rsp_data),
        .rsp_err      (rsp_err),
        .MEM_WrEn     (MEM_WrEn),
        .ALU_MEM_Addr (ALU_MEM_Addr),
        .MEM_DataIn   (MEM_DataIn),
        .MEM_DataOut  (MEM_DataOut)
    );

    always #5 clk = ~clk;

    // Synchronous data memory: read data appears the cycle after the address
    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 32'h0;
            MEM_DataOut <= 32'h0;
        end else begin
            if (MEM_WrEn) mem[ALU_MEM_Addr] <= MEM_DataIn;
            MEM_DataOut <= mem[ALU_MEM_Addr];
        end
    end

    // ---------------- reference model ----------------
    function automatic bit model_misaligned(input logic [11:0] a, input bit by);
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
        return !by && (a[1:0] != 2'b00);
`else
        return 1'b0;
`endif
    endfunction

    function automatic int model_lat(input bit we, input bit by, input logic [11:0] a);
        if (model_misaligned(a, by)) return 1;
        if (we && !by) return 2;
        if (we) return 4;
        return 3;
    endfunction

    function automatic logic [31:0] model_load(input logic [11:0] a, input bit by, input bit sx);
        logic [31:0] w;
        logic [7:0]  b;
        int          lane;
        w    = ref_mem[a[11:2]];
        lane = int'(a[1:0]);
        if (!by) return w;
        b = 8'(w >> (8 * lane));
        if (sx && b[7]) return {24'hFFFFFF, b};
        return {24'h000000, b};
    endfunction

    function automatic logic [31:0] model_merge(input logic [11:0] a, input bit by, input logic [31:0] wd);
        logic [31:0] mask;
        int          lane;
        if (!by) return wd;
        lane = int'(a[1:0]);
        mask = 32'hFF << (8 * lane);
        return (ref_mem[a[11:2]] & ~mask) | ({24'h0, wd[7:0]} << (8 * lane));
    endfunction

    // Presents one request at the current (IDLE) negedge and observes the
    // transaction until its response or a cycle budget runs out
    task automatic issue(input bit we, input bit by, input bit sx,
                         input logic [11:0] a, input logic [31:0] wd);
        req_valid = 1'b1;
        req_we    = we;
        req_byte  = by;
        req_sext  = sx;
        req_addr  = a;
        req_wdata = wd;
        obs_ready = req_ready;
        @(negedge clk);
        req_valid   = 1'b0;
        req_we      = 1'($urandom);
        req_byte    = 1'($urandom);
        req_sext    = 1'($urandom);
        req_addr    = 12'($urandom);
        req_wdata   = $urandom;
        obs_lat     = 0;
        obs_wr_cnt  = 0;
        obs_wr_cyc  = 0;
        obs_data    = 32'h0;
        obs_err     = 1'b0;
        obs_wr_addr = 10'h0;
        obs_wr_data = 32'h0;
        for (int c = 1; c <= 8 && obs_lat == 0; c++) begin
            if (c > 1) @(negedge clk);
            if (MEM_WrEn) begin
                obs_wr_cnt++;
                if (obs_wr_cyc == 0) obs_wr_cyc = c;
                obs_wr_addr = ALU_MEM_Addr;
                obs_wr_data = MEM_DataIn;
            end
            if (rsp_valid) begin
                obs_lat  = c;
                obs_data = rsp_data;
                obs_err  = rsp_err;
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        mem_clear = 1'b1;
        req_valid = 1'b0;
        req_we = 1'b0; req_byte = 1'b0; req_sext = 1'b0;
        req_addr = 12'h0; req_wdata = 32'h0;
        for (int i = 0; i < 1024; i++) ref_mem[i] = 32'h0;
        repeat (3) @(negedge clk);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready: got %b expected 1", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
        checks++; if (rsp_data !== 32'h0) begin errors++; $display("[TB] FAIL reset_rsp_data: got %h expected 0", rsp_data); end
        checks++; if (rsp_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_rsp_err: got %b expected 0", rsp_err); end
        checks++; if (MEM_WrEn !== 1'b0) begin errors++; $display("[TB] FAIL reset_wren: got %b expected 0", MEM_WrEn); end
        checks++; if (ALU_MEM_Addr !== 10'h0) begin errors++; $display("[TB] FAIL reset_addr: got %h expected 0", ALU_MEM_Addr); end
        checks++; if (MEM_DataIn !== 32'h0) begin errors++; $display("[TB] FAIL reset_datain: got %h expected 0", MEM_DataIn); end
        rst = 1'b0;
        mem_clear = 1'b0;
    endtask

    task automatic test_word_access();
        @(negedge clk); issue(1'b1, 1'b0, 1'b0, 12'h000, 32'd5);
        checks++; if (obs_ready !== 1'b1) begin errors++; $display("[TB] FAIL wst_ready: got %b expected 1", obs_ready); end
        checks++; if (obs_wr_cyc != 1) begin errors++; $display("[TB] FAIL wst_wr_cycle: got %0d expected 1", obs_wr_cyc); end
        checks++; if (obs_wr_addr !== 10'h0) begin errors++; $display("[TB] FAIL wst_addr: got %h expected 0", obs_wr_addr); end
        checks++; if (obs_wr_data !== 32'd5) begin errors++; $display("[TB] FAIL wst_data: got %h expected 5", obs_wr_data); end
        checks++; if (obs_lat != 2) begin errors++; $display("[TB] FAIL wst_latency: got %0d expected 2", obs_lat); end
        checks++; if (obs_data !== 32'h0) begin errors++; $display("[TB] FAIL wst_rsp_data: got %h expected 0", obs_data); end
        ref_mem[0] = 32'd5;

        @(negedge clk); issue(1'b1, 1'b0, 1'b0, 12'h004, 32'd666);
        ref_mem[1] = 32'd666;
        @(negedge clk); issue(1'b0, 1'b0, 1'b0, 12'h004, $urandom);
        checks++; if (obs_lat != 3) begin errors++; $display("[TB] FAIL wld_latency: got %0d expected 3", obs_lat); end
        checks++; if (obs_data !== 32'd666) begin errors++; $display("[TB] FAIL wld_data: got %h expected %h", obs_data, 32'd666); end
        checks++; if (obs_wr_cnt != 0) begin errors++; $display("[TB] FAIL wld_no_write: got %0d writes expected 0", obs_wr_cnt); end

        // Top word of the address space
        @(negedge clk); issue(1'b1, 1'b0, 1'b0, 12'hFFC, 32'hCAFE_0123);
        checks++; if (obs_wr_addr !== 10'h3FF) begin errors++; $display("[TB] FAIL wrap_addr: got %h expected 3ff", obs_wr_addr); end
        ref_mem[1023] = 32'hCAFE_0123;
    endtask

    task automatic test_byte_store();
        @(negedge clk); issue(1'b1, 1'b0, 1'b0, 12'h008, 32'h1122_3344);
        ref_mem[2] = 32'h1122_3344;
        @(negedge clk); issue(1'b1, 1'b1, 1'b0, 12'h009, {24'($urandom), 8'hAB});
        checks++; if (obs_wr_data !== 32'h1122_AB44) begin errors++; $display("[TB] FAIL bst_data: got %h expected 1122ab44", obs_wr_data); end
        checks++; if (obs_wr_cyc != 3) begin errors++; $display("[TB] FAIL bst_wr_cycle: got %0d expected 3", obs_wr_cyc); end
        checks++; if (obs_lat != 4) begin errors++; $display("[TB] FAIL bst_latency: got %0d expected 4", obs_lat); end
        ref_mem[2] = 32'h1122_AB44;
        @(negedge clk); issue(1'b0, 1'b0, 1'b0, 12'h008, 32'h0);
        checks++; if (obs_data !== 32'h1122_AB44) begin errors++; $display("[TB] FAIL bst_readback: got %h expected 1122ab44", obs_data); end
    endtask

    task automatic test_byte_load();
        @(negedge clk); issue(1'b1, 1'b0, 1'b0, 12'h008, 32'h80FF_0000);
        ref_mem[2] = 32'h80FF_0000;
        @(negedge clk); issue(1'b0, 1'b1, 1'b1, 12'h00A, 32'h0);
        checks++; if (obs_data !== 32'hFFFF_FFFF) begin errors++; $display("[TB] FAIL bld_sext: got %h expected ffffffff", obs_data); end
        checks++; if (obs_lat != 3) begin errors++; $display("[TB] FAIL bld_latency: got %0d expected 3", obs_lat); end
        @(negedge clk); issue(1'b0, 1'b1, 1'b0, 12'h00A, 32'h0);
        checks++; if (obs_data !== 32'h0000_00FF) begin errors++; $display("[TB] FAIL bld_zext: got %h expected 000000ff", obs_data); end
        @(negedge clk); issue(1'b0, 1'b1, 1'b1, 12'h00B, 32'h0);
        checks++; if (obs_data !== 32'hFFFF_FF80) begin errors++; $display("[TB] FAIL bld_lane3: got %h expected ffffff80", obs_data); end
    endtask

    task automatic test_misaligned();
        @(negedge clk); issue(1'b1, 1'b0, 1'b0, 12'h000, 32'h0BAD_F00D);
        ref_mem[0] = 32'h0BAD_F00D;
        @(negedge clk); issue(1'b0, 1'b0, 1'b0, 12'h002, 32'h0);
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
        checks++; if (obs_lat != 1) begin errors++; $display("[TB] FAIL mis_latency: got %0d expected 1", obs_lat); end
        checks++; if (obs_err !== 1'b1) begin errors++; $display("[TB] FAIL mis_err: got %b expected 1", obs_err); end
        checks++; if (obs_data !== 32'h0) begin errors++; $display("[TB] FAIL mis_data: got %h expected 0", obs_data); end
        @(negedge clk); issue(1'b1, 1'b0, 1'b0, 12'h003, 32'h1234_5678);
        checks++; if (obs_wr_cnt != 0) begin errors++; $display("[TB] FAIL mis_store_write: got %0d writes expected 0", obs_wr_cnt); end
`else
        checks++; if (obs_lat != 3) begin errors++; $display("[TB] FAIL mis_latency: got %0d expected 3", obs_lat); end
        checks++; if (obs_err !== 1'b0) begin errors++; $display("[TB] FAIL mis_err: got %b expected 0", obs_err); end
        checks++; if (obs_data !== 32'h0BAD_F00D) begin errors++; $display("[TB] FAIL mis_data: got %h expected 0badf00d", obs_data); end
        @(negedge clk); issue(1'b1, 1'b0, 1'b0, 12'h003, 32'h1234_5678);
        checks++; if (obs_wr_data !== 32'h1234_5678 || obs_wr_addr !== 10'h0) begin errors++; $display("[TB] FAIL mis_store_write: got %h@%h expected 12345678@000", obs_wr_data, obs_wr_addr); end
        ref_mem[0] = 32'h1234_5678;
`endif
    endtask

    task automatic test_back_to_back();
        @(negedge clk); issue(1'b0, 1'b0, 1'b0, 12'h004, 32'h0);
        // Now in the response cycle: present the next request immediately
        req_valid = 1'b1;
        req_we = 1'b0; req_byte = 1'b0; req_sext = 1'b0;
        req_addr = 12'h008; req_wdata = 32'h0;
        checks++; if (req_ready !== 1'b0) begin errors++; $display("[TB] FAIL b2b_ready_in_resp: got %b expected 0", req_ready); end
        @(negedge clk); issue(1'b0, 1'b0, 1'b0, 12'h008, 32'h0);
        checks++; if (obs_ready !== 1'b1) begin errors++; $display("[TB] FAIL b2b_ready_next: got %b expected 1", obs_ready); end
        checks++; if (obs_lat != 3 || obs_data !== ref_mem[2]) begin errors++; $display("[TB] FAIL b2b_second: got lat %0d data %h expected lat 3 data %h", obs_lat, obs_data, ref_mem[2]); end
    endtask

    task automatic test_reset_mid();
        int stray;
        logic [31:0] d;
        // Reset while a byte store waits on its read: nothing is written
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_byte = 1'b1; req_sext = 1'b0;
        req_addr = 12'h011; req_wdata = 32'h0000_005A;
        @(negedge clk); req_valid = 1'b0;
        @(negedge clk); rst = 1'b1;
        stray = (MEM_WrEn || rsp_valid) ? 1 : 0;
        @(negedge clk); rst = 1'b0;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("[TB] FAIL rstw_ready: got %b expected 1", req_ready); end
        for (int i = 0; i < 5; i++) begin
            if (MEM_WrEn || rsp_valid) stray++;
            @(negedge clk);
        end
        checks++; if (stray != 0) begin errors++; $display("[TB] FAIL rstw_activity: got %0d stray cycles expected 0", stray); end
        issue(1'b0, 1'b0, 1'b0, 12'h010, 32'h0);
        checks++; if (obs_data !== ref_mem[4]) begin errors++; $display("[TB] FAIL rstw_mem: got %h expected %h", obs_data, ref_mem[4]); end

        // Reset coinciding with WRITE of a word store: the write still lands
        d = $urandom;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_byte = 1'b0; req_sext = 1'b0;
        req_addr = 12'h014; req_wdata = d;
        @(negedge clk); req_valid = 1'b0; rst = 1'b1;
        checks++; if (MEM_WrEn !== 1'b1) begin errors++; $display("[TB] FAIL rstwr_wren: got %b expected 1", MEM_WrEn); end
        ref_mem[5] = d;
        @(negedge clk); rst = 1'b0;
        stray = 0;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("[TB] FAIL rstwr_ready: got %b expected 1", req_ready); end
        for (int i = 0; i < 4; i++) begin
            if (MEM_WrEn || rsp_valid) stray++;
            @(negedge clk);
        end
        checks++; if (stray != 0) begin errors++; $display("[TB] FAIL rstwr_activity: got %0d stray cycles expected 0", stray); end
        issue(1'b0, 1'b0, 1'b0, 12'h014, 32'h0);
        checks++; if (obs_data !== d) begin errors++; $display("[TB] FAIL rstwr_mem: got %h expected %h", obs_data, d); end
    endtask

    task automatic test_random();
        bit          we, by, sx, mis;
        logic [11:0] a;
        logic [31:0] wd, exp_data, exp_word;
        int          exp_lat, exp_wr;
        for (int n = 0; n < 60; n++) begin
            we  = 1'($urandom);
            by  = 1'($urandom);
            sx  = 1'($urandom);
            a   = 12'($urandom_range(0, 63));
            if (n % 10 == 9) a = 12'hFC0 | 12'($urandom_range(0, 63));
            wd  = $urandom;
            mis      = model_misaligned(a, by);
            exp_lat  = model_lat(we, by, a);
            exp_wr   = (we && !mis) ? 1 : 0;
            exp_data = (we || mis) ? 32'h0 : model_load(a, by, sx);
            exp_word = model_merge(a, by, wd);
            repeat ($urandom_range(1, 3)) @(negedge clk);
            issue(we, by, sx, a, wd);
            checks++; if (obs_lat != exp_lat) begin errors++; $display("[TB] FAIL rnd_latency[%0d]: got %0d expected %0d", n, obs_lat, exp_lat); end
            checks++; if (obs_data !== exp_data) begin errors++; $display("[TB] FAIL rnd_data[%0d]: got %h expected %h", n, obs_data, exp_data); end
            checks++; if (obs_err !== mis) begin errors++; $display("[TB] FAIL rnd_err[%0d]: got %b expected %b", n, obs_err, mis); end
            checks++; if (obs_wr_cnt != exp_wr) begin errors++; $display("[TB] FAIL rnd_writes[%0d]: got %0d expected %0d", n, obs_wr_cnt, exp_wr); end
            if (exp_wr == 1) begin
                checks++; if (obs_wr_data !== exp_word || obs_wr_addr !== a[11:2]) begin errors++; $display("[TB] FAIL rnd_wdata[%0d]: got %h@%h expected %h@%h", n, obs_wr_data, obs_wr_addr, exp_word, a[11:2]); end
                ref_mem[a[11:2]] = exp_word;
            end
        end
    endtask

    task automatic test_memory_image();
        int diffs = 0;
        @(negedge clk);
        for (int i = 0; i < 1024; i++) if (mem[i] !== ref_mem[i]) diffs++;
        checks++; if (diffs != 0) begin errors++; $display("[TB] FAIL memory_image: got %0d differing words expected 0", diffs); end
    endtask

    initial begin
        test_reset();
        test_word_access();
        test_byte_store();
        test_byte_load();
        test_misaligned();
        test_back_to_back();
        test_reset_mid();
        test_random();
        test_memory_image();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter: ADDR_W, 10, word-address width driven to data memory; byte address width is ADDR_W+2.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 req_valid  input  1  core presents an access request.
REQ-005 req_ready  output  1  controller can accept a request this cycle.
REQ-006 req_we  input  1  1 = store, 0 = load.
REQ-007 req_byte  input  1  1 = byte access, 0 = word access.
REQ-008 req_sext  input  1  byte load only: 1 = sign-extend, 0 = zero-extend.
REQ-009 req_addr  input  ADDR_W+2  byte address.
REQ-010 req_wdata  input  32  store data; byte store uses bits [7:0].
REQ-011 rsp_valid  output  1  one-cycle pulse: access complete.
REQ-012 rsp_data  output  32  load result, valid while rsp_valid=1.
REQ-013 rsp_err  output  1  access rejected, qualified by rsp_valid.
REQ-014 MEM_WrEn  output  1  data-memory write enable.
REQ-015 ALU_MEM_Addr  output  ADDR_W  data-memory word address = req_addr[ADDR_W+1:2].
REQ-016 MEM_DataIn  output  32  data-memory write data.
REQ-017 MEM_DataOut  input  32  data-memory read data; valid the cycle after ALU_MEM_Addr is presented.

Function
REQ-018 The controller SHALL implement states IDLE, READ, WAIT, WRITE, RESP; req_ready=1 only in IDLE.
REQ-019 A request SHALL be accepted when req_valid=1 and req_ready=1; all request fields are registered at acceptance and input changes afterwards are ignored.
REQ-020 Transitions from IDLE on acceptance: word store -> WRITE; any load or byte store -> READ.
REQ-021 READ -> WAIT unconditionally; WAIT -> WRITE for byte store, else -> RESP; WRITE -> RESP; RESP -> IDLE.
REQ-022 MEM_WrEn SHALL be 1 only in WRITE; ALU_MEM_Addr SHALL hold the registered word address in READ, WAIT, WRITE and be 0 in IDLE.
REQ-023 Byte lanes SHALL be little-endian: lane k = req_addr[1:0], occupying bits [8k+7:8k].
REQ-024 In WAIT, MEM_DataOut SHALL be captured; word load: rsp_data = captured word; byte load: selected lane, extended per req_sext.
REQ-025 Byte store: MEM_DataIn in WRITE = captured word with lane k replaced by req_wdata[7:0], other lanes unchanged; word store: MEM_DataIn = req_wdata.
REQ-026 Latency from acceptance cycle N: rsp_valid at N+2 (word store), N+3 (loads), N+4 (byte store).
REQ-027 rsp_valid SHALL be 1 only in RESP; rsp_data SHALL be 0 for stores; no backpressure on response.
REQ-028 Back-to-back: a request presented during RESP SHALL NOT be accepted; next acceptance earliest in the following IDLE cycle.
REQ-029 Address wrap: ALU_MEM_Addr is the truncated field; no carry or range check.

Reset
REQ-030 rst=1 at a rising edge SHALL force IDLE and clear rsp_valid, rsp_data, rsp_err, MEM_WrEn, ALU_MEM_Addr, MEM_DataIn to 0 and req_ready to 1 in the following cycle.
REQ-031 Reset mid-operation SHALL abort the access with no response; a WRITE-state cycle coinciding with rst still performs that write, no later write occurs.

Configuration
REQ-032 Macro MEM_ACCESS_ALIGN_CHECK_EN defined: word access with req_addr[1:0]!=0 SHALL go IDLE -> RESP directly, no memory access, rsp_err=1, rsp_data=0, rsp_valid at N+1.
REQ-033 Macro undefined: req_addr[1:0] ignored for word accesses; rsp_err SHALL be tied 0.

Verification
REQ-034 Reset then word store addr 0x000 data 5 -> MEM_WrEn=1 with ALU_MEM_Addr=0, MEM_DataIn=5 at N+1; rsp_valid at N+2.
REQ-035 Word store addr 0x004 data 666, then word load addr 0x004 -> rsp_data=666 at N+3.
REQ-036 Memory word 0x11223344 at word 2; byte store 0xAB to addr 0x009 -> written word 0x1122AB44; untouched lanes preserved.
REQ-037 Byte load addr 0x00A of word 0x80FF0000 with req_sext=1 -> 0xFFFFFFFF; with req_sext=0 -> 0x000000FF.
REQ-038 rst asserted in WAIT of a byte store -> no MEM_WrEn, no rsp_valid, req_ready=1 next cycle.
REQ-039 With MEM_ACCESS_ALIGN_CHECK_EN: word load addr 0x002 -> rsp_valid and rsp_err=1 at N+1, MEM_WrEn never asserted; without macro -> reads word 0.
